router_pkt_tx: RTL and testbench

ROUTER_PKT_TX -- requirements
Module: router_pkt_tx

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_pkt_tx_if.sv | 20 ++
 rtl/router_tx_buf.sv | 55 +++++
 rtl/router_pkt_tx.sv | 156 +++++++++++++++
 tb/tb_router_pkt_tx.sv | 273 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_pkg.sv
// Shared router definitions: FSM state type, payload limits and the byte-XOR CRC.
// Used by both the transmit and the receive side.
package router_pkg;

    localparam int MAX_PAYLOAD = 7;
    localparam int SIZE_W      = 3;

    typedef enum logic [2:0] {
        IDLE,
        SRC,
        DEST,
        SIZE,
        DATA,
        CRC
    } state_t;

    function automatic logic [7:0] crc_update(input logic [7:0] crc, input logic [7:0] data_byte);
        return crc ^ data_byte;
    endfunction

endpackage

// File: rtl/router_pkt_tx_if.sv
// Byte stream between the packet transmitter and the router input port.
interface router_pkt_tx_if;

    logic [7:0] pkt_out;
    logic       pkt_valid;
    logic       stop_packet_send;

    modport master (
        output pkt_out,
        output pkt_valid,
        input  stop_packet_send
    );

    modport slave (
        input  pkt_out,
        input  pkt_valid,
        output stop_packet_send
    );

endinterface

// File: rtl/router_tx_buf.sv
// Payload buffer for the transmitter: 7 x 8-bit regfile, count (doubles as write
// pointer), read pointer and registered full flag.
module router_tx_buf
    import router_pkg::*;
(
    input  logic              clk1,
    input  logic              reset,
    input  logic              i_wr,
    input  logic [7:0]        i_wr_data,
    input  logic              i_rd_adv,
    input  logic              i_clear,
    output logic [7:0]        o_rd_data,
    output logic [SIZE_W-1:0] o_count,
    output logic [SIZE_W-1:0] o_rd_ptr,
    output logic              o_full
);

    logic [7:0]        r_mem [0:MAX_PAYLOAD-1];
    logic [SIZE_W-1:0] r_count;
    logic [SIZE_W-1:0] r_rd_ptr;
    logic              r_full;

    // Clearing the count and pointers is enough to discard the payload.
    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else if (i_clear) begin
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_full   <= 1'b0;
        end else begin
            if (i_wr) begin
                r_count <= r_count + 1'b1;
                r_full  <= (r_count == SIZE_W'(MAX_PAYLOAD - 1));
            end
            if (i_rd_adv) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (i_wr) begin
            r_mem[r_count] <= i_wr_data;
        end
    end

    assign o_rd_data = (r_rd_ptr < SIZE_W'(MAX_PAYLOAD)) ? r_mem[r_rd_ptr] : 8'h00;
    assign o_count   = r_count;
    assign o_rd_ptr  = r_rd_ptr;
    assign o_full    = r_full;

endmodule

// File: rtl/router_pkt_tx.sv
// Router packet transmitter: SRC_ID, dest, size, payload, XOR CRC with back-pressure.
// Optional CRC corruption for error testing is enabled by ROUTER_TX_ERR_INJECT_EN.
module router_pkt_tx
    import router_pkg::*;
#(
    parameter logic [7:0] SRC_ID = 8'h01
) (
    input  logic       clk1,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [7:0] dest,
`ifdef ROUTER_TX_ERR_INJECT_EN
    input  logic       err_inject,
`endif
    router_pkt_tx_if.master tx,
    output logic       busy,
    output logic       buf_full,
    output logic       done
);

    state_t            r_state, w_state_next, w_load_state;
    logic [7:0]        r_pkt_out, w_pkt_out_next;
    logic [7:0]        r_crc, w_crc_next;
    logic [7:0]        r_dest, w_dest_next;
    logic              r_valid, w_valid_next;
    logic              r_busy, w_busy_next;
    logic              r_done, w_done_next;
    logic              r_err, w_err_next;
    logic              w_err_in;
    logic              w_wr, w_rd_adv, w_clear, w_accept, w_load;
    logic [7:0]        w_rd_data;
    logic [SIZE_W-1:0] w_count, w_rd_ptr;
    logic              w_full;

`ifdef ROUTER_TX_ERR_INJECT_EN
    assign w_err_in = err_inject;
`else
    assign w_err_in = 1'b0;
`endif

    assign w_wr     = (r_state == IDLE) && wr_en && !start && !w_full;
    assign w_accept = r_valid && !tx.stop_packet_send;

    router_tx_buf u_buf (
        .clk1      (clk1),
        .reset     (reset),
        .i_wr      (w_wr),
        .i_wr_data (wr_data),
        .i_rd_adv  (w_rd_adv),
        .i_clear   (w_clear),
        .o_rd_data (w_rd_data),
        .o_count   (w_count),
        .o_rd_ptr  (w_rd_ptr),
        .o_full    (w_full)
    );

    always_ff @(posedge clk1 or negedge reset) begin
        if (!reset) begin
            r_state   <= IDLE;
            r_pkt_out <= 8'h00;
            r_crc     <= 8'h00;
            r_dest    <= 8'h00;
            r_valid   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_err     <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_pkt_out <= w_pkt_out_next;
            r_crc     <= w_crc_next;
            r_dest    <= w_dest_next;
            r_valid   <= w_valid_next;
            r_busy    <= w_busy_next;
            r_done    <= w_done_next;
            r_err     <= w_err_next;
        end
    end

    // The state names the byte on the wire; the first SRC cycle has valid low,
    // which gives the one-cycle launch latency. Each byte is loaded exactly once.
    always_comb begin
        w_state_next   = r_state;
        w_pkt_out_next = r_pkt_out;
        w_crc_next     = r_crc;
        w_dest_next    = r_dest;
        w_valid_next   = r_valid;
        w_busy_next    = r_busy;
        w_done_next    = 1'b0;
        w_err_next     = r_err;
        w_rd_adv       = 1'b0;
        w_clear        = 1'b0;
        w_load         = 1'b0;
        w_load_state   = r_state;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_next = SRC;
                    w_busy_next  = 1'b1;
                    w_dest_next  = dest;
                    w_crc_next   = 8'h00;
                    w_err_next   = w_err_in;
                end
            end
            default: begin
                if (!r_valid) begin
                    w_load = 1'b1;
                end else if (w_accept) begin
                    w_crc_next = crc_update(r_crc, r_pkt_out);
                    w_load     = 1'b1;
                    case (r_state)
                        SRC:  w_state_next = DEST;
                        DEST: w_state_next = SIZE;
                        SIZE: w_state_next = (w_count == '0) ? CRC : DATA;
                        DATA: w_state_next = (w_rd_ptr == w_count) ? CRC : DATA;
                        CRC: begin
                            w_state_next   = IDLE;
                            w_load         = 1'b0;
                            w_pkt_out_next = 8'h00;
                            w_valid_next   = 1'b0;
                            w_busy_next    = 1'b0;
                            w_done_next    = 1'b1;
                            w_clear        = 1'b1;
                        end
                        default: w_state_next = IDLE;
                    endcase
                    w_load_state = w_state_next;
                end
            end
        endcase

        if (w_load) begin
            w_valid_next = 1'b1;
            case (w_load_state)
                SRC:  w_pkt_out_next = SRC_ID;
                DEST: w_pkt_out_next = r_dest;
                SIZE: w_pkt_out_next = {{(8 - SIZE_W){1'b0}}, w_count};
                DATA: begin
                    w_pkt_out_next = w_rd_data;
                    w_rd_adv       = 1'b1;
                end
                CRC:  w_pkt_out_next = w_crc_next ^ {7'b0, r_err};
                default: w_pkt_out_next = r_pkt_out;
            endcase
        end
    end

    assign tx.pkt_out   = r_pkt_out;
    assign tx.pkt_valid = r_valid;
    assign busy         = r_busy;
    assign done         = r_done;
    assign buf_full     = w_full;

endmodule

// File: tb/tb_router_pkt_tx.sv
// Directed self-checking bench for router_pkt_tx; the CRC corruption scenario is
// only compiled when ROUTER_TX_ERR_INJECT_EN is defined.
module tb_router_pkt_tx;

    logic       clk1 = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       start;
    logic [7:0] dest;
    logic       stopSend;
    logic       busy;
    logic       buf_full;
    logic       done;
`ifdef ROUTER_TX_ERR_INJECT_EN
    logic       errInject;
`endif

    int         passCount = 0;
    int         checkCount = 0;
    logic [7:0] rx [0:15];
    int         rxCount;
    bit         doneSeen;
    bit         holdOk;
    int         heldCycles;
    logic [7:0] expQ [$];

    router_pkt_tx_if txIf ();
    assign txIf.stop_packet_send = stopSend;

    router_pkt_tx #(.SRC_ID(8'h01)) dut (
        .clk1     (clk1),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .start    (start),
        .dest     (dest),
`ifdef ROUTER_TX_ERR_INJECT_EN
        .err_inject (errInject),
`endif
        .tx       (txIf),
        .busy     (busy),
        .buf_full (buf_full),
        .done     (done)
    );

    always #5 clk1 = ~clk1;

    task writeByte(input logic [7:0] d);
        wr_en   = 1'b1;
        wr_data = d;
        @(negedge clk1);
        wr_en   = 1'b0;
    endtask

    task startPacket(input logic [7:0] d);
        dest  = d;
        start = 1'b1;
        @(negedge clk1);
        start = 1'b0;
    endtask

    // Records accepted bytes until done; optionally stalls byte stallIdx for stallLen cycles.
    task collect(input int stallIdx, input int stallLen);
        int left;
        logic [7:0] heldVal;
        left = stallLen;
        heldVal = 8'h00;
        rxCount = 0;
        doneSeen = 1'b0;
        holdOk = 1'b1;
        heldCycles = 0;
        for (int i = 0; i < 16; i++) rx[i] = 8'hxx;
        for (int cyc = 0; cyc < 60; cyc++) begin
            if (done === 1'b1) begin
                doneSeen = 1'b1;
                break;
            end
            if (txIf.pkt_valid === 1'b1) begin
                if (left > 0 && rxCount == stallIdx) begin
                    if (heldCycles == 0) heldVal = txIf.pkt_out;
                    else if (txIf.pkt_out !== heldVal) holdOk = 1'b0;
                    heldCycles++;
                    left--;
                    stopSend = 1'b1;
                end else begin
                    if (heldCycles > 0 && rxCount == stallIdx && txIf.pkt_out !== heldVal) holdOk = 1'b0;
                    stopSend = 1'b0;
                    if (rxCount < 16) rx[rxCount] = txIf.pkt_out;
                    rxCount++;
                end
            end
            @(negedge clk1);
        end
        stopSend = 1'b0;
    endtask

    task test_reset();
        reset = 1'b1; wr_en = 1'b0; wr_data = 8'h00; start = 1'b0; dest = 8'h00; stopSend = 1'b0;
`ifdef ROUTER_TX_ERR_INJECT_EN
        errInject = 1'b0;
`endif
        #1 reset = 1'b0;
        #1;
        checkCount++; if (txIf.pkt_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", txIf.pkt_valid); else passCount++;
        checkCount++; if (txIf.pkt_out !== 8'h00) $display("[TB] FAIL reset_pkt_out: got %h expected 00", txIf.pkt_out); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (buf_full !== 1'b0) $display("[TB] FAIL reset_buf_full: got %b expected 0", buf_full); else passCount++;
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL reset_done: got %b expected 0", done); else passCount++;
        repeat (2) @(negedge clk1);
        reset = 1'b1;
        @(negedge clk1);
    endtask

    task test_basic_packet();
        writeByte(8'hAA);
        writeByte(8'h55);
        startPacket(8'h01);
        checkCount++; if (busy !== 1'b1) $display("[TB] FAIL basic_busy_rise: got %b expected 1", busy); else passCount++;
        checkCount++; if (txIf.pkt_valid !== 1'b0) $display("[TB] FAIL basic_latency_valid: got %b expected 0", txIf.pkt_valid); else passCount++;
        collect(-1, 0);
        // CRC = 01^01^02^AA^55 = FD
        expQ = '{8'h01, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFD};
        checkCount++; if (!doneSeen) $display("[TB] FAIL basic_timeout: got no done, expected done pulse"); else passCount++;
        checkCount++; if (rxCount !== expQ.size()) $display("[TB] FAIL basic_len: got %0d expected %0d", rxCount, expQ.size()); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL basic_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        checkCount++; if (txIf.pkt_valid !== 1'b0) $display("[TB] FAIL basic_gap_valid: got %b expected 0", txIf.pkt_valid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL basic_busy_fall: got %b expected 0", busy); else passCount++;
        @(negedge clk1);
        checkCount++; if (done !== 1'b0) $display("[TB] FAIL basic_done_width: got %b expected 0", done); else passCount++;
    endtask

    task test_empty_packet();
        // The write strobe in the start cycle must be dropped.
        wr_en = 1'b1; wr_data = 8'h99;
        startPacket(8'h02);
        wr_en = 1'b0;
        collect(-1, 0);
        expQ = '{8'h01, 8'h02, 8'h00, 8'h03};
        checkCount++; if (!doneSeen) $display("[TB] FAIL empty_timeout: got no done, expected done pulse"); else passCount++;
        checkCount++; if (rxCount !== expQ.size()) $display("[TB] FAIL empty_len: got %0d expected %0d", rxCount, expQ.size()); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL empty_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        @(negedge clk1);
    endtask

    task test_backpressure();
        writeByte(8'h11);
        writeByte(8'h22);
        writeByte(8'h33);
        startPacket(8'h05);
        collect(4, 3);
        // CRC = 01^05^03^11^22^33 = 07
        expQ = '{8'h01, 8'h05, 8'h03, 8'h11, 8'h22, 8'h33, 8'h07};
        checkCount++; if (!doneSeen) $display("[TB] FAIL stall_timeout: got no done, expected done pulse"); else passCount++;
        checkCount++; if (heldCycles !== 3) $display("[TB] FAIL stall_cycles: got %0d expected 3", heldCycles); else passCount++;
        checkCount++; if (holdOk !== 1'b1) $display("[TB] FAIL stall_hold: got changed byte, expected held byte"); else passCount++;
        checkCount++; if (rxCount !== expQ.size()) $display("[TB] FAIL stall_len: got %0d expected %0d", rxCount, expQ.size()); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL stall_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        @(negedge clk1);
    endtask

    task test_buf_full();
        for (int i = 1; i <= 6; i++) writeByte(8'(i));
        checkCount++; if (buf_full !== 1'b0) $display("[TB] FAIL full_after6: got %b expected 0", buf_full); else passCount++;
        writeByte(8'h07);
        checkCount++; if (buf_full !== 1'b1) $display("[TB] FAIL full_after7: got %b expected 1", buf_full); else passCount++;
        writeByte(8'h08);
        checkCount++; if (buf_full !== 1'b1) $display("[TB] FAIL full_after8: got %b expected 1", buf_full); else passCount++;
        startPacket(8'h03);
        collect(-1, 0);
        // XOR of 01..07 is 0, so CRC = 01^03^07 = 05
        expQ = '{8'h01, 8'h03, 8'h07, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h05};
        checkCount++; if (!doneSeen) $display("[TB] FAIL full_timeout: got no done, expected done pulse"); else passCount++;
        checkCount++; if (rxCount !== expQ.size()) $display("[TB] FAIL full_len: got %0d expected %0d", rxCount, expQ.size()); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL full_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        checkCount++; if (buf_full !== 1'b0) $display("[TB] FAIL full_cleared: got %b expected 0", buf_full); else passCount++;
        @(negedge clk1);
    endtask

    task test_busy_ignore();
        startPacket(8'h02);
        start = 1'b1; dest = 8'hEE; wr_en = 1'b1; wr_data = 8'h77;
        @(negedge clk1);
        start = 1'b0; wr_en = 1'b0;
        collect(-1, 0);
        expQ = '{8'h01, 8'h02, 8'h00, 8'h03};
        checkCount++; if (!doneSeen) $display("[TB] FAIL busy_timeout: got no done, expected done pulse"); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL busy_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        repeat (2) @(negedge clk1);
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL busy_no_relaunch: got %b expected 0", busy); else passCount++;
        startPacket(8'h09);
        collect(-1, 0);
        checkCount++; if (rx[2] !== 8'h00) $display("[TB] FAIL busy_write_ignored_size: got %h expected 00", rx[2]); else passCount++;
        checkCount++; if (rx[3] !== 8'h08) $display("[TB] FAIL busy_write_ignored_crc: got %h expected 08", rx[3]); else passCount++;
        @(negedge clk1);
    endtask

    task test_reset_mid_packet();
        bit found;
        found = 1'b0;
        writeByte(8'h11);
        writeByte(8'h22);
        startPacket(8'h06);
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (txIf.pkt_valid === 1'b1 && txIf.pkt_out === 8'h11) begin
                found = 1'b1;
                break;
            end
            @(negedge clk1);
        end
        checkCount++; if (!found) $display("[TB] FAIL rst_mid_reach_data: got no data byte, expected 11"); else passCount++;
        #2 reset = 1'b0;
        #1;
        checkCount++; if (txIf.pkt_valid !== 1'b0) $display("[TB] FAIL rst_mid_valid: got %b expected 0", txIf.pkt_valid); else passCount++;
        checkCount++; if (busy !== 1'b0) $display("[TB] FAIL rst_mid_busy: got %b expected 0", busy); else passCount++;
        checkCount++; if (txIf.pkt_out !== 8'h00) $display("[TB] FAIL rst_mid_pkt_out: got %h expected 00", txIf.pkt_out); else passCount++;
        @(negedge clk1);
        reset = 1'b1;
        @(negedge clk1);
        startPacket(8'h04);
        checkCount++; if (txIf.pkt_valid !== 1'b0) $display("[TB] FAIL rst_mid_latency: got %b expected 0", txIf.pkt_valid); else passCount++;
        collect(-1, 0);
        expQ = '{8'h01, 8'h04, 8'h00, 8'h05};
        checkCount++; if (rxCount !== expQ.size()) $display("[TB] FAIL rst_mid_len: got %0d expected %0d", rxCount, expQ.size()); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL rst_mid_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        @(negedge clk1);
    endtask

`ifdef ROUTER_TX_ERR_INJECT_EN
    task test_err_inject();
        writeByte(8'hAA);
        writeByte(8'h55);
        errInject = 1'b1;
        startPacket(8'h01);
        errInject = 1'b0;
        collect(-1, 0);
        expQ = '{8'h01, 8'h01, 8'h02, 8'hAA, 8'h55, 8'hFC};
        checkCount++; if (!doneSeen) $display("[TB] FAIL err_timeout: got no done, expected done pulse"); else passCount++;
        for (int i = 0; i < expQ.size(); i++) begin
            checkCount++; if (rx[i] !== expQ[i]) $display("[TB] FAIL err_byte%0d: got %h expected %h", i, rx[i], expQ[i]); else passCount++;
        end
        @(negedge clk1);
    endtask
`endif

    initial begin
        test_reset();
        test_basic_packet();
        test_empty_packet();
        test_backpressure();
        test_buf_full();
        test_busy_ignore();
        test_reset_mid_packet();
`ifdef ROUTER_TX_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
